updown_counter7seg_mux: RTL and testbench

Parametrised BCD up/down counter with a multiplexed N-digit seven-segment driver. It is the successor to the two-digit up-counter display block. It adds a configurable digit count, count direction, parallel BCD load, a wrap flag and selectable tick and refresh rates. It sits between the board clock/switches and the on-board 8-digit common-anode display.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/bcd_to_7seg.sv | 31 +++
 rtl/updown_counter7seg_mux.sv | 163 ++++++++++++++++
 tb/tb_updown_counter7seg_mux.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment codes (a = bit 6,
// g = bit 0), the BCD digit type and the all-anodes-off pattern.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [7:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank
// override. Non-BCD codes decode to blank.
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  bcd_t       digit,
  input  logic       blank,
  output logic [6:0] a_to_g
);

  // Decode the digit, or force all segments off when blanked
  always_comb begin
    a_to_g = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    a_to_g = SEG_0;
        4'd1:    a_to_g = SEG_1;
        4'd2:    a_to_g = SEG_2;
        4'd3:    a_to_g = SEG_3;
        4'd4:    a_to_g = SEG_4;
        4'd5:    a_to_g = SEG_5;
        4'd6:    a_to_g = SEG_6;
        4'd7:    a_to_g = SEG_7;
        4'd8:    a_to_g = SEG_8;
        4'd9:    a_to_g = SEG_9;
        default: a_to_g = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/updown_counter7seg_mux.sv
// BCD up/down counter of DIGITS digits with parallel load, wrap pulse and a
// multiplexed active-low seven-segment driver for an 8-digit display.
// Optional build macro UDCNT7SEG_BLANK_EN enables leading-zero blanking
// (digit 0 is never blanked).
module updown_counter7seg_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int TICK_DIV    = 50_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                  mclk,
  input  logic                  clr_n,
  input  logic                  pause,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [6:0]            a_to_g,
  output logic [7:0]            AN,
  output logic                  dp
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  // A load digit above 9 saturates to 9
  function automatic bcd_t sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic [PW-1:0]       presc_q;
  logic                tick;
  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_nx;
  logic [DIGITS:0]     carry;
  logic                wrap_q;
  logic [RW-1:0]       rdiv_q;
  logic                scan_step;
  logic [2:0]          scan_idx_q;

  // Tick is qualified by pause so a held prescaler at its top value
  // cannot produce repeated ticks.
  assign tick = ~pause && (presc_q == PW'(TICK_DIV - 1));

  // Prescaler: free-runs 0..TICK_DIV-1, holds on pause, cleared by load
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      presc_q <= '0;
    end else if (load) begin
      presc_q <= '0;
    end else if (!pause) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  // carry[i] means digit i must step this cycle; the same chain serves as
  // carry (counting up, digit at 9) or borrow (counting down, digit at 0).
  assign carry[0] = tick;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    bcd_t cur;
    bcd_t stepped;
    assign cur          = count_q[4*g +: 4];
    assign carry[g+1]   = carry[g] && (dir ? (cur == 4'd9) : (cur == 4'd0));
    assign stepped      = dir ? ((cur == 4'd9) ? 4'd0 : cur + 4'd1)
                              : ((cur == 4'd0) ? 4'd9 : cur - 4'd1);
    assign count_nx[4*g +: 4] = load     ? sat_digit(load_val[4*g +: 4]) :
                                carry[g] ? stepped : cur;
  end

  // Count register and wrap pulse; a ripple out of the top digit is a wrap
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_nx;
      wrap_q  <= ~load & carry[DIGITS];
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  assign scan_step = (rdiv_q == RW'(REFRESH_DIV - 1));

  // Scan divider and digit index: 0, 1, .., DIGITS-1, 0
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      rdiv_q     <= '0;
      scan_idx_q <= '0;
    end else begin
      rdiv_q <= scan_step ? '0 : rdiv_q + 1'b1;
      if (scan_step) begin
        scan_idx_q <= (scan_idx_q == 3'(DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
      end
    end
  end

  // ---- stage p0: select scanned digit, decode, build anode/dp pattern ----
  bcd_t       sel_digit_p0;
  logic       sel_blank_p0;
  logic [6:0] seg_p0;
  logic [7:0] an_p0;
  logic       dp_p0;

`ifdef UDCNT7SEG_BLANK_EN
  // lead_zero[i]: digit i and every digit above it are zero
  logic [DIGITS:0] lead_zero;
  assign lead_zero[DIGITS] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : gen_lz
    assign lead_zero[g] = lead_zero[g+1] && (count_q[4*g +: 4] == 4'd0);
  end
`endif

  // Mux the scanned digit, its blank flag and the matching anode
  always_comb begin
    sel_digit_p0 = '0;
    sel_blank_p0 = 1'b0;
    an_p0        = AN_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == 3'(i)) begin
        sel_digit_p0 = count_q[4*i +: 4];
        an_p0[i]     = 1'b0;
`ifdef UDCNT7SEG_BLANK_EN
        sel_blank_p0 = (i != 0) && lead_zero[i];
`endif
      end
    end
    dp_p0 = ~((scan_idx_q == 3'd0) && pause);
  end

  bcd_to_7seg u_seg (
    .digit  (sel_digit_p0),
    .blank  (sel_blank_p0),
    .a_to_g (seg_p0)
  );

  // ---- stage p1: segments, anodes and dp registered together ----
  logic [6:0] seg_p1;
  logic [7:0] an_p1;
  logic       dp_p1;

  // Register display outputs as one so digit and anode always match
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      seg_p1 <= SEG_0;
      an_p1  <= 8'hFE;
      dp_p1  <= 1'b1;
    end else begin
      seg_p1 <= seg_p0;
      an_p1  <= an_p0;
      dp_p1  <= dp_p0;
    end
  end

  assign a_to_g = seg_p1;
  assign AN     = an_p1;
  assign dp     = dp_p1;

endmodule

// File: tb/tb_updown_counter7seg_mux.sv
// Self-checking bench for updown_counter7seg_mux (DIGITS=2, TICK_DIV=4,
// REFRESH_DIV=2) against an integer-valued behavioural model.
module tb_updown_counter7seg_mux;

  localparam int DIGITS      = 2;
  localparam int TICK_DIV    = 4;
  localparam int REFRESH_DIV = 2;
  localparam int MODV        = 10 ** DIGITS;

  logic                mclk = 1'b0;
  logic                clr_n = 1'b0;
  logic                pause = 1'b0;
  logic                dir = 1'b1;
  logic                load = 1'b0;
  logic [4*DIGITS-1:0] load_val = '0;
  logic [4*DIGITS-1:0] count;
  logic                wrap;
  logic [6:0]          a_to_g;
  logic [7:0]          AN;
  logic                dp;

  int total = 0;
  int bad   = 0;

  updown_counter7seg_mux #(
    .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .mclk(mclk), .clr_n(clr_n), .pause(pause), .dir(dir), .load(load),
    .load_val(load_val), .count(count), .wrap(wrap), .a_to_g(a_to_g),
    .AN(AN), .dp(dp)
  );

  always #5 mclk = ~mclk;

  // Segment codes for 0..9, active-low, a in bit 6
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  // Model state: count as a plain integer, prescaler/scan as cycle counters
  int         m_cnt, m_pre, m_rdiv, m_idx;
  logic       m_wrap;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  function automatic int pow10(input int n);
    return 10 ** n;
  endfunction

  function automatic logic [6:0] disp_seg(input int idx, input int cnt);
`ifdef UDCNT7SEG_BLANK_EN
    if (idx > 0 && cnt < pow10(idx)) return 7'b1111111;
`endif
    return seg_tab[(cnt / pow10(idx)) % 10];
  endfunction

  function automatic int load_value(input logic [4*DIGITS-1:0] lv);
    int v = 0;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * pow10(i);
    end
    return v;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_rdiv = 0; m_idx = 0; m_wrap = 1'b0;
    e_an = 8'hFE; e_seg = 7'b0000001; e_dp = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic model_edge();
    logic [7:0] n_an;
    logic       tk;
    if (!clr_n) begin
      model_reset();
      return;
    end
    n_an = 8'hFF;
    n_an[m_idx] = 1'b0;
    e_seg = disp_seg(m_idx, m_cnt);
    e_dp  = !(m_idx == 0 && pause);
    e_an  = n_an;
    tk = !pause && (m_pre == TICK_DIV - 1);
    if (load) begin
      m_cnt = load_value(load_val); m_pre = 0; m_wrap = 1'b0;
    end else begin
      if (!pause) m_pre = (m_pre + 1) % TICK_DIV;
      if (tk && dir) begin
        m_wrap = (m_cnt == MODV - 1); m_cnt = (m_cnt + 1) % MODV;
      end else if (tk) begin
        m_wrap = (m_cnt == 0); m_cnt = (m_cnt + MODV - 1) % MODV;
      end else begin
        m_wrap = 1'b0;
      end
    end
    if (m_rdiv == REFRESH_DIV - 1) begin
      m_rdiv = 0; m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_rdiv++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(to_bcd(m_cnt)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("AN", 32'(AN), 32'(e_an));
    check("a_to_g", 32'(a_to_g), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic step();
    @(posedge mclk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #23;
    check_all();
    repeat (3) step();

    // Release reset, count up 40 cycles
    clr_n = 1'b1;
    repeat (40) step();

    // Load 99, count up through the wrap
    load = 1'b1; load_val = 8'h99; step(); load = 1'b0;
    repeat (6) step();
    check("after_up_wrap", 32'(count), 32'(to_bcd(m_cnt)));

    // Load 00, count down through the wrap
    dir = 1'b0; load = 1'b1; load_val = 8'h00; step(); load = 1'b0;
    repeat (6) step();

    // Pause mid-count for 20 cycles, then resume
    dir = 1'b1; repeat (5) step();
    pause = 1'b1; repeat (20) step();
    pause = 1'b0; repeat (10) step();

    // Load coincident with a tick, out-of-range digit clamps
    for (int k = 0; k < TICK_DIV + 1 && m_pre != TICK_DIV - 1; k++) step();
    check("tick_align", 32'(m_pre), 32'(TICK_DIV - 1));
    load = 1'b1; load_val = 8'h3C; step(); load = 1'b0;
    check("load_clamp", 32'(count), 32'h39);
    repeat (5) step();

    // Held count of 05 shown on both digits (tens blank when enabled)
    pause = 1'b1; load = 1'b1; load_val = 8'h05; step(); load = 1'b0;
    repeat (5) step();
    pause = 1'b0;

    // Randomized operation
    for (int n = 0; n < 300; n++) begin
      if (n % 8 == 0) dir = 1'($urandom_range(0, 1));
      pause    = ($urandom_range(0, 7) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      step();
    end
    load = 1'b0; pause = 1'b0;

    // Asynchronous reset mid-count, away from the clock edge
    repeat (7) step();
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) step();
    clr_n = 1'b1;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
